// File: rtl/audio_pkg.sv
// Shared mode encodings and width helpers for the audio mixer slice.
package audio_pkg;

   typedef enum logic [1:0] {
      MODE_MIX  = 2'd0,
      MODE_SOLO = 2'd1,
      MODE_OFF  = 2'd2,
      MODE_TONE = 2'd3
   } mode_e;

   // Largest possible mix sum: every channel on at full volume.
   function automatic int full_f(input int channels, input int volbits);
      return channels * ((1 << volbits) - 1);
   endfunction

   function automatic int sumbits_f(input int channels, input int volbits);
      return $clog2(full_f(channels, volbits) + 1);
   endfunction

   // acc stays below FULL, so acc + level never reaches 2*FULL.
   function automatic int accbits_f(input int channels, input int volbits);
      return $clog2(2 * full_f(channels, volbits));
   endfunction

   function automatic int selbits_f(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/audio_mixer_activity.sv
// Single-channel activity stretcher: any change of the registered channel
// level (re)loads a hold down-counter; the flag is high while it is non-zero.
module activity_stretch #(
   parameter int HOLDCYCLES = 200_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ch_q,
   output logic active
);

   localparam int CNTBITS = $clog2(HOLDCYCLES + 1);

   logic               ch_prev;
   logic [CNTBITS-1:0] hold_cnt;

   // Edge detect against the previous level; a retrigger restarts the hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ch_prev  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         ch_prev <= ch_q;
         if (ch_q != ch_prev) begin
            hold_cnt <= CNTBITS'(HOLDCYCLES);
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

   assign active = (hold_cnt != '0);

endmodule

// File: rtl/audio_mixer.sv
// N-channel audio mixer: per-channel volume/mute, registered mix sum,
// first-order sigma-delta 1-bit output, solo/off/test-tone modes and
// per-channel activity flags.
//
// state (mode_q) | meaning
// MODE_MIX       | sigma-delta of the summed, volume-weighted channels
// MODE_SOLO      | pwm follows the selected channel directly
// MODE_OFF       | output silent
// MODE_TONE      | square wave, half-period 2^TONEDIV cycles
module audio_mixer
   import audio_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int VOLBITS    = 4,
   parameter int HOLDCYCLES = 200_000,
   parameter int TONEDIV    = 10
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [CHANNELS-1:0]                   ch_in,
   input  logic [CHANNELS*VOLBITS-1:0]           vol,
   input  logic [CHANNELS-1:0]                   mute,
   input  logic [1:0]                            mode,
   input  logic [selbits_f(CHANNELS)-1:0]        sel,
   output logic [sumbits_f(CHANNELS,VOLBITS)-1:0] level,
   output logic                                  pwm,
   output logic [CHANNELS-1:0]                   active
);

   localparam int FULL    = full_f(CHANNELS, VOLBITS);
   localparam int SUMBITS = sumbits_f(CHANNELS, VOLBITS);
   localparam int ACCBITS = accbits_f(CHANNELS, VOLBITS);
   localparam int SELBITS = selbits_f(CHANNELS);

   mode_e               mode_cur;
   mode_e               mode_q;
   logic [CHANNELS-1:0] ch_q;
   logic [ACCBITS-1:0]  acc;
   logic [TONEDIV-1:0]  tone_cnt;

   logic [SUMBITS-1:0]  level_d;
   logic [ACCBITS-1:0]  sum_s;
   logic [ACCBITS-1:0]  acc_d;
   logic [TONEDIV-1:0]  tone_d;
   logic                pwm_d;
   logic                solo_bit;
   logic [VOLBITS-1:0]  solo_vol;

   assign mode_cur = mode_e'(mode);
   assign sum_s    = acc + ACCBITS'(level);

   // Stage-2 level: weighted sum, solo pick, or silence depending on mode.
   always_comb begin
      level_d  = '0;
      solo_bit = 1'b0;
      solo_vol = '0;
      // An out-of-range sel matches no channel and so selects silence.
      for (int i = 0; i < CHANNELS; i++) begin
         if (SELBITS'(i) == sel) begin
            solo_bit = ch_q[i] & ~mute[i];
            solo_vol = vol[i*VOLBITS +: VOLBITS];
         end
      end
      case (mode_cur)
         MODE_MIX: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (ch_q[i] && !mute[i]) begin
                  level_d = level_d + SUMBITS'(vol[i*VOLBITS +: VOLBITS]);
               end
            end
         end
         MODE_SOLO: level_d = solo_bit ? SUMBITS'(solo_vol) : '0;
         default:   level_d = '0;
      endcase
   end

   // Output stage next state; a mode change parks acc and pwm at zero for one cycle.
   always_comb begin
      pwm_d  = 1'b0;
      acc_d  = '0;
      tone_d = '0;
      if (mode_cur == mode_q) begin
         case (mode_cur)
            MODE_MIX: begin
               if (sum_s >= ACCBITS'(FULL)) begin
                  pwm_d = 1'b1;
                  acc_d = sum_s - ACCBITS'(FULL);
               end else begin
                  acc_d = sum_s;
               end
            end
            MODE_SOLO: pwm_d = solo_bit;
            MODE_TONE: begin
               tone_d = tone_cnt + 1'b1;
               pwm_d  = (&tone_cnt) ? ~pwm : pwm;
            end
            default: pwm_d = 1'b0;
         endcase
      end
   end

   // Pipeline and mode registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ch_q     <= '0;
         mode_q   <= MODE_MIX;
         level    <= '0;
         acc      <= '0;
         pwm      <= 1'b0;
         tone_cnt <= '0;
      end else begin
         ch_q     <= ch_in;
         mode_q   <= mode_cur;
         level    <= level_d;
         acc      <= acc_d;
         pwm      <= pwm_d;
         tone_cnt <= tone_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_act
      activity_stretch #(
         .HOLDCYCLES(HOLDCYCLES)
      ) u_act (
         .clk    (clk),
         .reset_n(reset_n),
         .ch_q   (ch_q[i]),
         .active (active[i])
      );
   end

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer with a cycle-level reference model.
module tb_audio_mixer;

   localparam int CH   = 4;
   localparam int VB   = 4;
   localparam int HOLD = 8;
   localparam int TD   = 3;
   localparam int FULL = CH * ((1 << VB) - 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [CH-1:0] ch_in;
   logic [CH*VB-1:0] vol;
   logic [CH-1:0] mute;
   logic [1:0]    mode;
   logic [1:0]    sel;
   logic [5:0]    level;
   logic          pwm;
   logic [CH-1:0] active;

   audio_mixer #(
      .CHANNELS  (CH),
      .VOLBITS   (VB),
      .HOLDCYCLES(HOLD),
      .TONEDIV   (TD)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .ch_in  (ch_in),
      .vol    (vol),
      .mute   (mute),
      .mode   (mode),
      .sel    (sel),
      .level  (level),
      .pwm    (pwm),
      .active (active)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model state
   int      m_level;
   bit      m_pwm;
   int      m_acc;
   int      m_tone_k;
   bit [3:0] m_chq, m_chq_prev;
   bit [1:0] m_mode_q;
   int      last_trig [CH];
   bit      trig_ok   [CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int vol_of(input int i);
      return int'((vol >> (i * VB)) & 16'hF);
   endfunction

   // Advances the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int nl;
      int s;
      bit sb;
      cyc++;
      if (!reset_n) begin
         m_level = 0; m_pwm = 0; m_acc = 0; m_tone_k = 0;
         m_chq = '0; m_chq_prev = '0; m_mode_q = 2'd0;
         for (int i = 0; i < CH; i++) trig_ok[i] = 1'b0;
         return;
      end
      for (int i = 0; i < CH; i++) begin
         if (m_chq[i] != m_chq_prev[i]) begin
            trig_ok[i]   = 1'b1;
            last_trig[i] = cyc;
         end
      end
      sb = (int'(sel) < CH) && m_chq[sel] && !mute[sel];
      nl = 0;
      if (mode == 2'd0) begin
         for (int i = 0; i < CH; i++) if (m_chq[i] && !mute[i]) nl += vol_of(i);
      end else if (mode == 2'd1) begin
         nl = sb ? vol_of(int'(sel)) : 0;
      end
      if (mode != m_mode_q) begin
         m_pwm = 0; m_acc = 0; m_tone_k = 0;
      end else begin
         case (mode)
            2'd0: begin
               s = m_acc + m_level;
               m_pwm = (s >= FULL);
               m_acc = m_pwm ? s - FULL : s;
               m_tone_k = 0;
            end
            2'd1: begin m_pwm = sb; m_acc = 0; m_tone_k = 0; end
            2'd2: begin m_pwm = 0;  m_acc = 0; m_tone_k = 0; end
            default: begin
               m_tone_k++;
               m_pwm = bit'((m_tone_k >> TD) & 1);
               m_acc = 0;
            end
         endcase
      end
      m_level    = nl;
      m_chq_prev = m_chq;
      m_chq      = ch_in;
      m_mode_q   = mode;
   endtask

   task automatic step();
      logic [CH-1:0] exp_act;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < CH; i++)
         exp_act[i] = trig_ok[i] && ((cyc - last_trig[i]) < HOLD);
      check("model_level", 32'(level), 32'(m_level));
      check("model_pwm", 32'(pwm), 32'(m_pwm));
      check("model_active", 32'(active), 32'(exp_act));
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   typedef struct {
      logic [3:0]  ch;
      logic [15:0] v;
      logic [3:0]  mu;
      logic [1:0]  md;
      logic [1:0]  sl;
      int          exp_level;
      bit          chk_pwm;
      bit          exp_pwm;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int highs;
      int consec;
      int first_hi;
      int rise0;
      int rise1;
      bit last_p;
      bit prev_in;
      bit cur;

      vecs[0] = '{4'hF, 16'hFFFF, 4'h0, 2'd0, 2'd0, 60, 1'b1, 1'b1};
      vecs[1] = '{4'h1, 16'hFFFF, 4'h0, 2'd0, 2'd0, 15, 1'b0, 1'b0};
      vecs[2] = '{4'hF, 16'h1234, 4'h0, 2'd0, 2'd0, 10, 1'b0, 1'b0};
      vecs[3] = '{4'hF, 16'hFFFF, 4'h1, 2'd0, 2'd0, 45, 1'b0, 1'b0};
      vecs[4] = '{4'h4, 16'hFFFF, 4'h0, 2'd1, 2'd2, 15, 1'b1, 1'b1};
      vecs[5] = '{4'h4, 16'hFFFF, 4'h4, 2'd1, 2'd2, 0,  1'b1, 1'b0};
      vecs[6] = '{4'hF, 16'hFFFF, 4'h0, 2'd2, 2'd0, 0,  1'b1, 1'b0};
      vecs[7] = '{4'hA, 16'hA5C3, 4'h0, 2'd0, 2'd0, 22, 1'b0, 1'b0};
      vecs[8] = '{4'hF, 16'hA5C3, 4'h0, 2'd1, 2'd3, 10, 1'b1, 1'b1};
      vecs[9] = '{4'hA, 16'hA5C3, 4'h8, 2'd0, 2'd0, 12, 1'b0, 1'b0};

      // Reset with everything driven high
      reset_n = 1'b0; ch_in = 4'hF; vol = 16'hFFFF; mute = '0; mode = 2'd0; sel = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("reset_level", 32'(level), 0);
         check("reset_pwm", 32'(pwm), 0);
         check("reset_active", 32'(active), 0);
      end
      reset_n = 1'b1;
      step();
      check("post_reset_level_1", 32'(level), 0);
      step();
      check("post_reset_level_2", 32'(level), 60);
      step();
      check("full_scale_pwm", 32'(pwm), 1);

      // Table-driven steady-state vectors
      for (int t = 0; t < 10; t++) begin
         ch_in = vecs[t].ch; vol = vecs[t].v; mute = vecs[t].mu;
         mode = vecs[t].md; sel = vecs[t].sl;
         steps(4);
         check($sformatf("vec%0d_level", t), 32'(level), 32'(vecs[t].exp_level));
         if (vecs[t].chk_pwm) check($sformatf("vec%0d_pwm", t), 32'(pwm), 32'(vecs[t].exp_pwm));
      end

      // Partial duty: level 15 of 60 gives one high in four
      ch_in = 4'h1; vol = 16'hFFFF; mute = '0; mode = 2'd0; sel = '0;
      steps(6);
      highs = 0; consec = 0; last_p = pwm;
      for (int k = 0; k < 400; k++) begin
         step();
         if (pwm) highs++;
         if (pwm && last_p) consec++;
         last_p = pwm;
      end
      check("duty_highs", 32'(highs), 100);
      check("duty_consecutive", 32'(consec), 0);

      // Mode switch mix -> off -> mix restarts the accumulator
      mode = 2'd2;
      step();
      check("mode_change_pwm_off", 32'(pwm), 0);
      steps(5);
      mode = 2'd0;
      step();
      check("mode_change_pwm_mix", 32'(pwm), 0);
      highs = 0; first_hi = -1;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (pwm) begin
            highs++;
            if (first_hi < 0) first_hi = k;
         end
      end
      check("restart_first_high", 32'(first_hi), 4);
      check("restart_highs", 32'(highs), 15);

      // Mute of channel 0 with all channels at full volume
      ch_in = 4'hF;
      steps(4);
      check("mute_before", 32'(level), 60);
      mute = 4'h1;
      steps(2);
      check("mute_after", 32'(level), 45);

      // Solo on channel 2 with a toggling input
      mute = '0; mode = 2'd1; sel = 2'd2; ch_in = 4'h0;
      steps(3);
      prev_in = ch_in[2];
      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0) ch_in[2] = ~ch_in[2];
         cur = ch_in[2];
         step();
         check("solo_follow", 32'(pwm), 32'(prev_in));
         prev_in = cur;
      end
      mute = 4'h4;
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 0) ch_in[2] = ~ch_in[2];
         step();
         if (k >= 1) check("solo_muted", 32'(pwm), 0);
      end

      // Activity: single toggle, then a retrigger five cycles in
      mute = '0; mode = 2'd0; ch_in = 4'h0;
      steps(12);
      ch_in[1] = 1'b1;
      highs = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (active[1]) highs++;
      end
      check("hold_single", 32'(highs), HOLD);
      ch_in[1] = 1'b0;
      highs = 0;
      for (int k = 0; k < 25; k++) begin
         if (k == 5) ch_in[1] = 1'b1;
         step();
         if (active[1]) highs++;
      end
      check("hold_retrigger", 32'(highs), HOLD + 5);

      // Test tone: period 2 * 2^TD cycles, level zero
      mode = 2'd3; ch_in = 4'hF;
      step();
      check("tone_change_pwm", 32'(pwm), 0);
      rise0 = -1; rise1 = -1; last_p = pwm;
      for (int k = 1; k <= 64; k++) begin
         step();
         if (pwm && !last_p) begin
            if (rise0 < 0) rise0 = k;
            else if (rise1 < 0) rise1 = k;
         end
         last_p = pwm;
      end
      check("tone_first_rise", 32'(rise0), 32'(1 << TD));
      check("tone_period", 32'(rise1 - rise0), 32'(2 << TD));
      check("tone_level", 32'(level), 0);

      // Reset in the middle of activity
      mode = 2'd0; ch_in = 4'h5;
      steps(3);
      reset_n = 1'b0;
      step();
      check("midreset_level", 32'(level), 0);
      check("midreset_pwm", 32'(pwm), 0);
      check("midreset_active", 32'(active), 0);
      reset_n = 1'b1;

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) ch_in = CH'($urandom);
         if ($urandom_range(0, 15) == 0) vol = 16'($urandom);
         if ($urandom_range(0, 15) == 0) mute = CH'($urandom);
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 15) == 0) sel = 2'($urandom);
         reset_n = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
